// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolver with a PC-indexed table of 2-bit saturating counters.
// IF reads the table combinationally; EX resolves the branch, redirects, trains and counts.
module branch_resolve_bht #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic             ex_ltu,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic [1:0]       pc_src_default,
  output logic [1:0]       pc_src,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0][1:0] bht_q, bht_d;
  logic [CNT_W-1:0]      bcnt_q, bcnt_d, mcnt_q, mcnt_d;
  logic [IDX_W-1:0]      if_idx, ex_idx;
  logic [1:0]            ex_ctr;
  logic                  legal, actual, res_valid;
  logic                  unused_pc_bits;

  // Word-aligned PCs: bits [1:0] carry no information, upper bits alias.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign if_pred_taken = bht_q[if_idx][1];
  assign ex_ctr        = bht_q[ex_idx];

  always_comb begin
    legal  = 1'b1;
    actual = 1'b0;
    case (ex_funct3)
      3'b000:  actual = ex_zero;
      3'b001:  actual = ~ex_zero;
      3'b100:  actual = ex_lt;
      3'b101:  actual = ~ex_lt;
      3'b110:  actual = ex_ltu;
      3'b111:  actual = ~ex_ltu;
      default: legal  = 1'b0;
    endcase
  end

  assign res_valid = ex_valid & ex_branch & legal;

  always_comb begin
    pc_src = pc_src_default;
    flush  = 1'b0;
    if (res_valid) begin
      pc_src = 2'b00;
      if (actual & ~ex_pred_taken) begin
        pc_src = 2'b01;
        flush  = 1'b1;
      end else if (~actual & ex_pred_taken) begin
        pc_src = 2'b11;
        flush  = 1'b1;
      end
    end
  end

  always_comb begin
    bht_d  = bht_q;
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (res_valid) begin
      if (actual && ex_ctr != 2'b11)
        bht_d[ex_idx] = ex_ctr + 2'b01;
      else if (!actual && ex_ctr != 2'b00)
        bht_d[ex_idx] = ex_ctr - 2'b01;
      // Statistics saturate rather than wrap so long runs stay meaningful.
      if (bcnt_q != {CNT_W{1'b1}})
        bcnt_d = bcnt_q + 1'b1;
      if (flush && mcnt_q != {CNT_W{1'b1}})
        mcnt_d = mcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bht_q  <= {DEPTH{2'b01}};
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bht_q  <= bht_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign branch_count  = bcnt_q;
  assign mispred_count = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scenario bench for branch_resolve_bht: redirect expectations go through a scoreboard queue,
// predictor and counter state are checked after each clock.
module tb_branch_resolve_bht;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   if_pc;
  logic          if_pred_taken;
  logic          ex_valid, ex_branch, ex_zero, ex_lt, ex_ltu, ex_pred_taken;
  logic [2:0]    ex_funct3;
  logic [31:0]   ex_pc;
  logic [1:0]    pc_src_default, pc_src;
  logic          flush;
  logic [CW-1:0] branch_count, mispred_count;

  typedef struct {
    string      nm;
    logic [2:0] v;   // {flush, pc_src}
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   bc_m  = 0;
  int   mc_m  = 0;

  always #5 clk = ~clk;

  branch_resolve_bht #(.IDX_W(4), .PC_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .pc_src_default(pc_src_default),
    .pc_src(pc_src), .flush(flush),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  // Drive one EX-stage instruction and queue the redirect the spec demands for it.
  task automatic drive_ex(input logic v, input logic br, input logic [2:0] f3,
                          input logic z, input logic lt, input logic ltu,
                          input logic [31:0] pc, input logic pred,
                          input logic [1:0] def, input logic [2:0] exp_v,
                          input string nm);
    ex_valid = v; ex_branch = br; ex_funct3 = f3;
    ex_zero = z; ex_lt = lt; ex_ltu = ltu;
    ex_pc = pc; ex_pred_taken = pred; pc_src_default = def;
    sb.push_back('{nm, exp_v});
    if (v && br && f3[2:1] != 2'b01) begin
      if (bc_m < 15) bc_m++;
      if (exp_v[2] && mc_m < 15) mc_m++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ex_valid = 1'b0; ex_branch = 1'b0; ex_funct3 = 3'b000;
    ex_zero = 1'b0; ex_lt = 1'b0; ex_ltu = 1'b0; ex_pc = '0;
    ex_pred_taken = 1'b0; pc_src_default = 2'b00; if_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1 total++;
      if (if_pred_taken !== 1'b0) begin
        bad++; $display("FAIL reset_pred idx=%0d got=%b want=0", i, if_pred_taken);
      end
    end
    total++;
    if (branch_count !== '0 || mispred_count !== '0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", branch_count, mispred_count);
    end
  endtask

  task automatic test_first_mispredict();
    drive_ex(1, 1, 3'b000, 1, 0, 0, 32'h40, 0, 2'b10, 3'b101, "beq_taken_pred0");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    next_cycle();
    if_pc = 32'h40;
    #1 total++;
    if (if_pred_taken !== 1'b1) begin
      bad++; $display("FAIL t2_pred got=%b want=1", if_pred_taken);
    end
    total++;
    if (branch_count !== 4'd1 || mispred_count !== 4'd1) begin
      bad++; $display("FAIL t2_counts got=%0d/%0d want=1/1", branch_count, mispred_count);
    end
  endtask

  task automatic test_saturation();
    if_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1, 1, 3'b101, 0, 0, 0, 32'h40, 1, 2'b10, 3'b000, "bge_taken_pred1");
      #1 e = sb.pop_front(); total++;
      if ({flush, pc_src} !== e.v) begin
        bad++; $display("FAIL %s[%0d] got=%b want=%b", e.nm, i, {flush, pc_src}, e.v);
      end
      next_cycle();
      total++;
      if (if_pred_taken !== 1'b1) begin
        bad++; $display("FAIL sat_pred[%0d] got=%b want=1", i, if_pred_taken);
      end
    end
    // From the saturated state one not-taken keeps taken prediction, a second drops it.
    for (int i = 0; i < 2; i++) begin
      drive_ex(1, 1, 3'b101, 0, 1, 0, 32'h40, 1, 2'b10, 3'b111, "bge_nt_pred1");
      #1 e = sb.pop_front(); total++;
      if ({flush, pc_src} !== e.v) begin
        bad++; $display("FAIL %s[%0d] got=%b want=%b", e.nm, i, {flush, pc_src}, e.v);
      end
      next_cycle();
      total++;
      if (if_pred_taken !== (i == 0)) begin
        bad++; $display("FAIL nt_pred[%0d] got=%b want=%b", i, if_pred_taken, (i == 0));
      end
    end
    total++;
    if (branch_count !== 4'd6 || mispred_count !== 4'd3) begin
      bad++; $display("FAIL t3_counts got=%0d/%0d want=6/3", branch_count, mispred_count);
    end
  endtask

  task automatic test_passthrough();
    drive_ex(1, 1, 3'b010, 1, 1, 1, 32'h40, 1, 2'b10, 3'b010, "illegal_010");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    next_cycle();
    drive_ex(1, 1, 3'b011, 0, 0, 0, 32'h40, 1, 2'b01, 3'b001, "illegal_011");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    next_cycle();
    drive_ex(0, 1, 3'b001, 0, 0, 0, 32'h1C, 0, 2'b11, 3'b011, "bubble_bne");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    next_cycle();
    if_pc = 32'h1C;
    #1 total++;
    if (if_pred_taken !== 1'b0) begin
      bad++; $display("FAIL bubble_trained got=%b want=0", if_pred_taken);
    end
    total++;
    if (branch_count !== 4'd6 || mispred_count !== 4'd3) begin
      bad++; $display("FAIL t4_counts got=%0d/%0d want=6/3", branch_count, mispred_count);
    end
  endtask

  task automatic test_aliasing();
    // Entry 0 sits at WN here; train taken while IF looks up the same entry.
    if_pc = 32'h40;
    drive_ex(1, 1, 3'b000, 1, 0, 0, 32'h40, 0, 2'b00, 3'b101, "alias_train");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    total++;
    if (if_pred_taken !== 1'b0) begin
      bad++; $display("FAIL same_cycle_old got=%b want=0", if_pred_taken);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pcs [3];
      logic        wants [3];
      pcs   = '{32'h80, 32'h40, 32'h44};
      wants = '{1'b1, 1'b1, 1'b0};
      if_pc = pcs[i];
      #1 total++;
      if (if_pred_taken !== wants[i]) begin
        bad++; $display("FAIL alias_pred pc=%h got=%b want=%b", pcs[i], if_pred_taken, wants[i]);
      end
    end
  endtask

  task automatic test_conditions();
    logic [2:0] f3  [11] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100,
                             3'b101, 3'b110, 3'b110, 3'b111, 3'b111};
    logic       zv  [11] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic       ltv [11] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    logic       luv [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    logic       act [11] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      drive_ex(1, 1, f3[i], zv[i], ltv[i], luv[i], 32'(((i < 6) ? i + 1 : i + 2) * 4),
               0, 2'b10, act[i] ? 3'b101 : 3'b000, "cond");
      #1 e = sb.pop_front(); total++;
      if ({flush, pc_src} !== e.v) begin
        bad++; $display("FAIL %s[%0d] f3=%b got=%b want=%b", e.nm, i, f3[i], {flush, pc_src}, e.v);
      end
      next_cycle();
    end
    total++;
    if (branch_count !== CW'(bc_m) || mispred_count !== CW'(mc_m)) begin
      bad++; $display("FAIL cond_counts got=%0d/%0d want=%0d/%0d",
                      branch_count, mispred_count, bc_m, mc_m);
    end
  endtask

  task automatic test_stat_saturate_and_reset();
    for (int i = 0; i < 20; i++) begin
      drive_ex(1, 1, 3'b000, 1, 0, 0, 32'h3C, 0, 2'b00, 3'b101, "sat_mispred");
      #1 e = sb.pop_front(); total++;
      if ({flush, pc_src} !== e.v) begin
        bad++; $display("FAIL %s[%0d] got=%b want=%b", e.nm, i, {flush, pc_src}, e.v);
      end
      next_cycle();
    end
    total++;
    if (branch_count !== 4'hF || mispred_count !== 4'hF) begin
      bad++; $display("FAIL stat_sat got=%0d/%0d want=15/15", branch_count, mispred_count);
    end
    // Reset lands on a training edge: history and counts must be discarded.
    rst = 1'b0;
    drive_ex(1, 1, 3'b000, 1, 0, 0, 32'h40, 0, 2'b00, 3'b101, "train_in_reset");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    next_cycle();
    rst = 1'b1; bc_m = 0; mc_m = 0;
    if_pc = 32'h40;
    #1 total++;
    if (if_pred_taken !== 1'b0) begin
      bad++; $display("FAIL rst_train_pred got=%b want=0", if_pred_taken);
    end
    total++;
    if (branch_count !== '0 || mispred_count !== '0) begin
      bad++; $display("FAIL rst_train_counts got=%0d/%0d want=0/0", branch_count, mispred_count);
    end
    // One taken from WN must reach WT, proving the entry came back as 01.
    drive_ex(1, 1, 3'b000, 1, 0, 0, 32'h40, 0, 2'b00, 3'b101, "post_reset_train");
    #1 e = sb.pop_front(); total++;
    if ({flush, pc_src} !== e.v) begin
      bad++; $display("FAIL %s got=%b want=%b", e.nm, {flush, pc_src}, e.v);
    end
    next_cycle();
    total++;
    if (if_pred_taken !== 1'b1 || branch_count !== 4'd1) begin
      bad++; $display("FAIL post_reset got pred=%b bc=%0d want pred=1 bc=1",
                      if_pred_taken, branch_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_mispredict();
    test_saturation();
    test_passthrough();
    test_aliasing();
    test_conditions();
    test_stat_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
